// File: rtl/yin_front_end_if.sv
// Sample/control bundle between the audio source, the YIN front end and the detector.
interface yin_front_end_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned SIG_WIDTH = 9
);
  logic signed [IN_WIDTH-1:0] audio_in;
  logic                       audio_in_valid;
  logic                       done_in;
  logic [SIG_WIDTH-1:0]       sig_out;
  logic                       sig_out_valid;
  logic                       start_computation;
  logic                       silent_frame;
  logic                       overrun_out;

  modport master (
    output audio_in, audio_in_valid, done_in,
    input  sig_out, sig_out_valid, start_computation, silent_frame, overrun_out
  );

  modport slave (
    input  audio_in, audio_in_valid, done_in,
    output sig_out, sig_out_valid, start_computation, silent_frame, overrun_out
  );
endinterface

// File: rtl/yin_front_end.sv
// Decimating, re-coding front end for the YIN detector: boxcar average, round/saturate to
// offset binary, and gate one start pulse per HOP output samples on loudness and detector idle.
module yin_front_end #(
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned SIG_WIDTH     = 9,
  parameter int unsigned DECIMATION    = 4,
  parameter int unsigned HOP           = 500,
  parameter int unsigned SILENCE_LEVEL = 8
) (
  input logic             clk_in,
  input logic             rst_in,
  yin_front_end_if.slave  bus
);
  localparam int unsigned DecBits = $clog2(DECIMATION);
  localparam int unsigned AccW    = IN_WIDTH + DecBits;
  localparam int unsigned HopW    = $clog2(HOP);
  localparam int unsigned MagW    = SIG_WIDTH - 1;
  localparam int          RoundK  = 2 ** (IN_WIDTH - SIG_WIDTH - 1);

  localparam logic signed [IN_WIDTH:0]  MaxPos = {2'b00, {(IN_WIDTH - 1){1'b1}}};
  localparam logic [SIG_WIDTH-1:0]      MaxQ   = {1'b0, {(SIG_WIDTH - 1){1'b1}}};
  localparam logic [DecBits-1:0]        GrpLast = DecBits'(DECIMATION - 1);
  localparam logic [HopW-1:0]           HopLast = HopW'(HOP - 1);
  localparam logic [MagW-1:0]           SilLvl  = MagW'(SILENCE_LEVEL);

  logic signed [AccW-1:0]     r_acc;
  logic [DecBits-1:0]         r_grp;
  logic [HopW-1:0]            r_hop;
  logic [MagW-1:0]            r_peak;
  logic                       r_idle;
  logic [SIG_WIDTH-1:0]       r_sig_out;
  logic                       r_sig_valid;
  logic                       r_start;
  logic                       r_silent;
  logic                       r_overrun;

  logic signed [AccW-1:0]     w_sum;
  logic signed [IN_WIDTH-1:0] w_mean;
  logic signed [IN_WIDTH:0]   w_round;
  logic [SIG_WIDTH-1:0]       w_q;
  logic [SIG_WIDTH-1:0]       w_sig;
  logic [MagW-1:0]            w_low;
  logic [MagW-1:0]            w_mag;
  logic [MagW-1:0]            w_peak_new;
  logic                       w_frame_end;
  logic                       w_quiet;
  logic                       w_start_now;

  always_comb begin
    w_sum   = r_acc + $signed({{DecBits{bus.audio_in[IN_WIDTH-1]}}, bus.audio_in});
    // Upper IN_WIDTH bits of the sum are the floor of sum / DECIMATION.
    w_mean  = w_sum[AccW-1:DecBits];
    w_round = $signed({w_mean[IN_WIDTH-1], w_mean}) + $signed((IN_WIDTH + 1)'(RoundK));
    w_q     = (w_round > MaxPos) ? MaxQ : w_round[IN_WIDTH-1 -: SIG_WIDTH];
    w_sig   = {~w_q[SIG_WIDTH-1], w_q[SIG_WIDTH-2:0]};
  end

  // Distance from mid-scale; the one out-of-range value (sig_out = 0) saturates.
  always_comb begin
    w_low = r_sig_out[MagW-1:0];
    if (r_sig_out[SIG_WIDTH-1]) begin
      w_mag = w_low;
    end else if (w_low == '0) begin
      w_mag = '1;
    end else begin
      w_mag = ~w_low + MagW'(1);
    end
    w_peak_new  = (w_mag > r_peak) ? w_mag : r_peak;
    w_frame_end = r_sig_valid && (r_hop == HopLast);
    w_quiet     = (w_peak_new < SilLvl);
    w_start_now = w_frame_end && !w_quiet && r_idle;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_acc       <= '0;
      r_grp       <= '0;
      r_hop       <= '0;
      r_peak      <= '0;
      r_idle      <= 1'b1;
      r_sig_out   <= '0;
      r_sig_valid <= 1'b0;
      r_start     <= 1'b0;
      r_silent    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sig_valid <= 1'b0;
      r_start     <= w_start_now;
      r_silent    <= w_frame_end && w_quiet;
      r_overrun   <= w_frame_end && !w_quiet && !r_idle;

      if (bus.audio_in_valid) begin
        if (r_grp == GrpLast) begin
          r_acc       <= '0;
          r_grp       <= '0;
          r_sig_out   <= w_sig;
          r_sig_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_grp <= r_grp + DecBits'(1);
        end
      end

      if (r_sig_valid) begin
        if (w_frame_end) begin
          r_hop  <= '0;
          r_peak <= '0;
        end else begin
          r_hop  <= r_hop + HopW'(1);
          r_peak <= w_peak_new;
        end
      end

      // A start issued this cycle overrides a coincident done.
      if (w_start_now) begin
        r_idle <= 1'b0;
      end else if (bus.done_in) begin
        r_idle <= 1'b1;
      end
    end
  end

  assign bus.sig_out           = r_sig_out;
  assign bus.sig_out_valid     = r_sig_valid;
  assign bus.start_computation = r_start;
  assign bus.silent_frame      = r_silent;
  assign bus.overrun_out       = r_overrun;
endmodule

// File: doc/yin_front_end.md
Name: yin_front_end

Overview:
- Upstream conditioning stage for the YIN pitch detector.
- Takes signed audio samples at DECIMATION × 8 kHz and boxcar-averages each group of DECIMATION samples.
- Rounds, saturates and re-codes each average to SIG_WIDTH-bit offset binary, then presents it as the detector's sig_in/sig_in_valid stream.
- Every HOP output samples it issues a one-cycle start_computation to the detector. The start is suppressed on silent frames and on frames where the detector is still busy, with pulses flagging each case.

Parameters:
- IN_WIDTH, 16, width of signed two's-complement audio_in.
- SIG_WIDTH, 9, width of unsigned offset-binary sig_out; must be < IN_WIDTH.
- DECIMATION, 4, input samples per output sample; power of two, ≥ 2.
- HOP, 500, output samples per analysis frame; equals the detector window size.
- SILENCE_LEVEL, 8, minimum frame peak |sig_out − 2^(SIG_WIDTH−1)| required to start computation.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-low reset.
- audio_in  input  IN_WIDTH  signed audio sample.
- audio_in_valid  input  1  audio_in qualifier, single-cycle per sample.
- done_in  input  1  detector result pulse (detector f_out_valid).
- sig_out  output  SIG_WIDTH  decimated offset-binary sample (detector sig_in).
- sig_out_valid  output  1  one-cycle qualifier for sig_out.
- start_computation  output  1  one-cycle frame start pulse to detector.
- silent_frame  output  1  one-cycle pulse: frame suppressed, peak below SILENCE_LEVEL.
- overrun_out  output  1  one-cycle pulse: frame dropped, detector busy.

Behaviour:
- Reset (rst_in low, asynchronous; released synchronously by clk_in):
  - Outputs: sig_out = 0; sig_out_valid, start_computation, silent_frame and overrun_out all = 0.
  - Internal: accumulator, group counter, hop counter and peak register cleared; detector-idle flag set to 1.
  - Reset mid-group or mid-frame discards all partial state; no output pulse follows.
- Decimation:
  - Accumulator width is IN_WIDTH + log2(DECIMATION), signed.
  - Each audio_in_valid adds sign-extended audio_in and increments the group counter (0..DECIMATION−1).
  - On the DECIMATION-th valid: mean = (acc + audio_in) >>> log2(DECIMATION), arithmetic floor. The accumulator then restarts at 0.
  - No backpressure exists. Cycles without audio_in_valid change nothing.
- Re-coding, all on mean (IN_WIDTH signed):
  - r = mean + 2^(IN_WIDTH−SIG_WIDTH−1), computed with one guard bit.
  - If r > 2^(IN_WIDTH−1)−1, clamp r to 2^(IN_WIDTH−1)−1.
  - q = r[IN_WIDTH−1 -: SIG_WIDTH]; sig_out = q with MSB inverted (offset binary, 0 → 256).
- Output timing:
  - sig_out and sig_out_valid are registered. sig_out_valid is high exactly one cycle, the cycle after the completing audio_in_valid.
  - sig_out holds its value between valids.
- Peak tracking:
  - mag = |sig_out − 2^(SIG_WIDTH−1)|, SIG_WIDTH−1 bits; 256 − 0 saturates to 255.
  - peak = max(peak, mag) on each output sample.
- Hop counter:
  - Counts 0..HOP−1 on each sig_out_valid.
  - The partial decimation group carries across frame boundaries.
- Frame end, at the HOP-th sig_out_valid (counter wraps to 0):
  - The peak used includes this last sample.
  - On the next cycle exactly one of these occurs:
    - peak < SILENCE_LEVEL → silent_frame = 1.
    - Otherwise, detector-idle = 1 → start_computation = 1 and detector-idle ← 0.
    - Otherwise → overrun_out = 1.
  - The peak register is cleared for the new frame.
- Start timing: start_computation always trails the frame's last sig_out_valid by exactly one cycle, so the detector has already stored the last sample.
- Detector-idle flag:
  - Set by done_in.
  - done_in while already idle is ignored.
  - A start and a done_in in the same cycle: the start wins (flag = 0). This cannot occur legally, but is defined anyway.
- Flow control: silent and overrun frames do not stall sample flow; the next frame starts counting immediately.

Test Plan:
- Reset:
  - Assert rst_in low mid-group after 2 valids → all outputs 0 immediately, without waiting for a clock edge.
  - Release, then feed 4 × 0x4000 → the first output after release is sig_out = 0x180 (group was restarted).
- Re-coding values (4 identical samples each):
  - 4 × 0x0000 → sig_out = 0x100.
  - 4 × 0x003F → 0x100.
  - 4 × 0x0040 → 0x101.
  - 4 × 0x4000 → 0x180.
  - Each arrives with sig_out_valid one cycle after the 4th input valid.
- Saturation:
  - 4 × 0x7FFF → 0x1FF, with no wrap to 0x000.
  - 4 × 0x8000 → 0x000.
  - Alternating 0x7FFF / 0x8000 → mean −1 → 0x100.
- Silence:
  - 2000 zero inputs (500 outputs) → one silent_frame pulse one cycle after the 500th sig_out_valid.
  - No start_computation is issued.
- Start/overrun:
  - Two loud frames (0x4000/0xC000 square wave) with done_in never pulsed → start_computation after frame 1 and overrun_out after frame 2.
  - Then pulse done_in once → frame 3 produces start_computation.
- Idle gaps: random gaps of 0–10 cycles between audio_in_valid → same sig_out sequence and frame pulses as the back-to-back run.
